div_mul_unit: RTL

Multicycle signed multiply/divide unit in the execute path of the multicycle MIPS datapath. It consumes operands from the A/B registers when the control unit pulses `start`, and produces the 64-bit HI/LO result over roughly 33 cycles. The control unit waits in its DIVM state until `done`, then writes HI/LO through the div/mul write-back path.

---
 rtl/div_mul_pkg.sv | 21 ++
 rtl/div_mul_negate.sv | 18 +
 rtl/div_mul_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/div_mul_pkg.sv
// rtl/div_mul_pkg.sv - shared types and constants for the multicycle multiply/divide unit
package div_mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter must hold WIDTH-1 with a spare bit of headroom.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/div_mul_negate.sv
// rtl/div_mul_negate.sv - conditional two's-complement negate
module div_mul_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  // Negation wraps modulo 2^W, so -(2^(W-1)) maps onto itself as an unsigned magnitude.
  always_comb begin
    result = value;
    if (neg) begin
      result = (~value) + {{(W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/div_mul_unit.sv
// rtl/div_mul_unit.sv - multicycle signed MULT/DIV producing HI/LO; optional DIVMUL_FAST_MULT_EN
module div_mul_unit
  import div_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);

  state_t               state;
  state_t               state_next;

  logic                 op_q;
  logic                 sign_a;
  logic                 sign_b;
  logic                 dz_pending;
  logic [CW-1:0]        cnt;
  // Multiplicand for MULT, divisor for DIV (unsigned magnitude).
  logic [WIDTH-1:0]     mcand;
  // MULT: {partial product, multiplier}; DIV: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_next;

  logic                 start_dz;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod_raw;
  logic [2*WIDTH-1:0]   prod_fixed;
  logic [WIDTH-1:0]     quo_fixed;
  logic [WIDTH-1:0]     rem_fixed;

  assign start_dz = (op == OP_DIV) && (b == '0);

  div_mul_negate #(.W(WIDTH)) u_mag_a (
    .value  (a),
    .neg    (a[WIDTH-1]),
    .result (mag_a)
  );

  div_mul_negate #(.W(WIDTH)) u_mag_b (
    .value  (b),
    .neg    (b[WIDTH-1]),
    .result (mag_b)
  );

`ifdef DIVMUL_FAST_MULT_EN
  // Single-cycle unsigned product of the latched magnitudes; sign applied below.
  assign prod_raw = {{WIDTH{1'b0}}, mcand} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
  assign prod_raw = acc;
`endif

  div_mul_negate #(.W(2*WIDTH)) u_fix_prod (
    .value  (prod_raw),
    .neg    (sign_a ^ sign_b),
    .result (prod_fixed)
  );

  div_mul_negate #(.W(WIDTH)) u_fix_quo (
    .value  (acc[WIDTH-1:0]),
    .neg    (sign_a ^ sign_b),
    .result (quo_fixed)
  );

  // Remainder takes the dividend's sign so that truncation is toward zero.
  div_mul_negate #(.W(WIDTH)) u_fix_rem (
    .value  (acc[2*WIDTH-1:WIDTH]),
    .neg    (sign_a),
    .result (rem_fixed)
  );

  // One shift-add (MULT) or restoring-divide (DIV) step on the accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, mcand};
    acc_next  = acc;
    if (op_q == OP_MULT) begin
      if (acc[0]) begin
        acc_next = {mul_sum, acc[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc[2*WIDTH-1:1]};
      end
    end else begin
      if (!div_diff[WIDTH]) begin
        acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (start_dz) begin
            state_next = DONE;
          end else begin
`ifdef DIVMUL_FAST_MULT_EN
            state_next = (op == OP_MULT) ? FIX : CALC;
`else
            state_next = CALC;
`endif
          end
        end
      end
      CALC: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state; busy stays high in DONE only for divide-by-zero.
  always_comb begin
    done     = (state == DONE);
    div_zero = (state == DONE) && dz_pending;
    busy     = (state == CALC) || (state == FIX) || ((state == DONE) && dz_pending);
  end

  // Operand capture, iteration and HI/LO write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q       <= OP_MULT;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      dz_pending <= 1'b0;
      cnt        <= '0;
      mcand      <= '0;
      acc        <= '0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dz_pending <= start_dz;
            if (!start_dz) begin
              op_q   <= op;
              sign_a <= a[WIDTH-1];
              sign_b <= b[WIDTH-1];
              cnt    <= '0;
              if (op == OP_DIV) begin
                mcand <= mag_b;
                acc   <= {{WIDTH{1'b0}}, mag_a};
              end else begin
                mcand <= mag_a;
                acc   <= {{WIDTH{1'b0}}, mag_b};
              end
            end
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          if (op_q == OP_MULT) begin
            hi <= prod_fixed[2*WIDTH-1:WIDTH];
            lo <= prod_fixed[WIDTH-1:0];
          end else begin
            hi <= rem_fixed;
            lo <= quo_fixed;
          end
        end
        DONE: begin
          dz_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
